// File: rtl/dcsk_tx_pkg.sv
// Shared types and constants for the DCSK transmitter and its chip generator.
package dcsk_tx_pkg;

  localparam int MSG_W  = 32;
  localparam int LFSR_W = 32;
  localparam int MAX_SF = 16;
  localparam int BIT_W  = $clog2(MSG_W);
  localparam int CNT_W  = $clog2(MAX_SF);

  // Galois taps for x^32 + x^22 + x^2 + x + 1, right-shifting form.
  localparam logic [LFSR_W-1:0] LFSR_POLY = 32'h8020_0003;

  typedef enum logic [1:0] {SF2 = 2'd0, SF4 = 2'd1, SF8 = 2'd2, SF16 = 2'd3} sf_t;

  typedef enum logic [1:0] {IDLE = 2'd0, REF = 2'd1, DATA = 2'd2} tx_state_t;

  // Index of the last chip in a half-bit: SF-1.
  function automatic logic [CNT_W-1:0] sf_last(sf_t s);
    logic [CNT_W:0] n;
    n = (CNT_W'(2) << s) - 1'b1;
    return n[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/dcsk_lfsr.sv
// Galois LFSR pseudo-chaotic chip source with seed load; zero seed maps to 1.
module dcsk_lfsr
  import dcsk_tx_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_arst_n,
  input  logic              i_load,
  input  logic [LFSR_W-1:0] i_seed,
  input  logic              i_adv,
  output logic              o_chip
);

  logic [LFSR_W-1:0] state;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state <= LFSR_W'(1);
    end else if (i_load) begin
      state <= (i_seed == '0) ? LFSR_W'(1) : i_seed;
    end else if (i_adv) begin
      state <= (state >> 1) ^ (state[0] ? LFSR_POLY : '0);
    end
  end

  assign o_chip = state[0];

endmodule

// File: rtl/dcsk_tx.sv
// DCSK transmitter: per message bit, SF reference chips then SF data chips
// (reference replayed, inverted for a 0 bit), MSB first.
module dcsk_tx
  import dcsk_tx_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_arst_n,
  input  logic [LFSR_W-1:0] i_seed,
  input  logic              i_load_seed,
  input  logic              i_send,
  input  logic [MSG_W-1:0]  i_msg,
  input  logic [1:0]        i_sf,
  output logic              o_tx,
  output logic              o_is_sending
);

  tx_state_t         state;
  logic [MSG_W-1:0]  msg_r;
  sf_t               sf_r;
  logic [BIT_W-1:0]  bit_idx;
  logic [CNT_W-1:0]  cnt, cnt_nxt, rd_idx;
  logic [MAX_SF-1:0] rbuf;
  logic              busy, last, emit_ref, chip, data_chip, seed_load;

  // State always reflects the chip currently on o_tx, so the edge that
  // consumes chip SF-1 is the one that decides what comes next.
  always_comb begin
    last      = (cnt == sf_last(sf_r));
    cnt_nxt   = last ? '0 : cnt + 1'b1;
    rd_idx    = sf_last(sf_r) - cnt_nxt;
    data_chip = ~(rbuf[rd_idx] ^ msg_r[bit_idx]);
    emit_ref  = 1'b0;
    unique case (state)
      IDLE:    emit_ref = i_send;
      REF:     emit_ref = !last;
      DATA:    emit_ref = last && (bit_idx != '0);
      default: emit_ref = 1'b0;
    endcase
  end

  assign seed_load = (state == IDLE) && i_load_seed && !i_send;

  dcsk_lfsr u_lfsr (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .i_load   (seed_load),
    .i_seed   (i_seed),
    .i_adv    (emit_ref),
    .o_chip   (chip)
  );

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state   <= IDLE;
      o_tx    <= 1'b0;
      busy    <= 1'b0;
      cnt     <= '0;
      bit_idx <= '0;
      msg_r   <= '0;
      sf_r    <= SF2;
      rbuf    <= '0;
    end else begin
      // Newest reference chip enters at bit 0; chip k sits at SF-1-k.
      if (emit_ref) rbuf <= {rbuf[MAX_SF-2:0], chip};
      unique case (state)
        IDLE: begin
          if (i_send) begin
            state   <= REF;
            o_tx    <= chip;
            busy    <= 1'b1;
            cnt     <= '0;
            bit_idx <= BIT_W'(MSG_W - 1);
            msg_r   <= i_msg;
            sf_r    <= sf_t'(i_sf);
          end else begin
            o_tx <= 1'b0;
            busy <= 1'b0;
          end
        end
        REF: begin
          cnt <= cnt_nxt;
          if (last) begin
            state <= DATA;
            o_tx  <= data_chip;
          end else begin
            o_tx <= chip;
          end
        end
        DATA: begin
          cnt <= cnt_nxt;
          if (!last) begin
            o_tx <= data_chip;
          end else if (bit_idx != '0) begin
            bit_idx <= bit_idx - 1'b1;
            state   <= REF;
            o_tx    <= chip;
          end else begin
            state <= IDLE;
            o_tx  <= 1'b0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          o_tx  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Combinational busy in IDLE lets a requester see acceptance immediately.
  assign o_is_sending = busy | ((state == IDLE) & i_send);

endmodule

// File: tb/tb_dcsk_tx.sv
// Directed bench for dcsk_tx: captures chip frames and demodulates them by
// correlating the reference and data halves of each bit.
module tb_dcsk_tx;

  logic        clk = 1'b0;
  logic        arst_n;
  logic [31:0] seed;
  logic        load_seed;
  logic        send;
  logic [31:0] msg;
  logic [1:0]  sf;
  logic        tx;
  logic        is_sending;

  int tests = 0;
  int fails = 0;
  bit cap  [0:2199];
  bit keep [0:2199];

  always #5 clk = ~clk;

  dcsk_tx dut (
    .i_clk        (clk),
    .i_arst_n     (arst_n),
    .i_seed       (seed),
    .i_load_seed  (load_seed),
    .i_send       (send),
    .i_msg        (msg),
    .i_sf         (sf),
    .o_tx         (tx),
    .o_is_sending (is_sending)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called just after a negedge with the DUT idle; returns just after the
  // negedge of the first idle cycle following the frame.
  task automatic send_frame(input logic [31:0] m, input logic [1:0] s, input bit disturb,
                            output int len, output logic [31:0] dm,
                            output bit all_eq, output bit all_inv, output bit comb_busy);
    int sfv, corr, base;
    msg = m; sf = s; send = 1'b1;
    #1 comb_busy = is_sending;
    @(posedge clk); #1 send = 1'b0;
    len = 0;
    forever begin
      @(negedge clk);
      if (load_seed) load_seed = 1'b0;
      if (!is_sending || len >= 2100) break;
      cap[len] = tx;
      len++;
      if (disturb && len == 100) begin
        load_seed = 1'b1; seed = 32'h1357_9BDF; sf = 2'd0; msg = 32'h0;
      end
    end
    sfv = 2 << s; dm = '0; all_eq = 1'b1; all_inv = 1'b1;
    for (int b = 0; b < 32; b++) begin
      base = b * 2 * sfv; corr = 0;
      for (int k = 0; k < sfv; k++) begin
        if (cap[base+k] == cap[base+sfv+k]) begin corr++; all_inv = 1'b0; end
        else begin corr--; all_eq = 1'b0; end
      end
      dm[31-b] = (corr > 0);
    end
  endtask

  task automatic load(input logic [31:0] sd);
    seed = sd; load_seed = 1'b1;
    @(negedge clk); load_seed = 1'b0;
  endtask

  function automatic logic [31:0] head(input int n);
    logic [31:0] g = '0;
    for (int i = 0; i < n; i++) g = {g[30:0], cap[i]};
    return g;
  endfunction

  initial begin
    int len, gap, errs;
    logic [31:0] dm, rm;
    bit eq, inv, cb;
    logic [1:0] rs;
    logic [31:0] lens [0:3];
    lens[0] = 128; lens[1] = 256; lens[2] = 512; lens[3] = 1024;

    arst_n = 1'b0; seed = '0; load_seed = 1'b0; send = 1'b0; msg = '0; sf = '0;
    repeat (2) @(negedge clk);
    chk("rst_tx", {31'b0, tx}, 32'd0);
    chk("rst_busy", {31'b0, is_sending}, 32'd0);
    arst_n = 1'b1;
    @(negedge clk);

    load(32'hDEAD_BEEF);
    send_frame(32'hFFFF_FFFF, 2'd0, 1'b0, len, dm, eq, inv, cb);
    chk("comb_busy", {31'b0, cb}, 32'd1);
    chk("ones_len", len, 32'd128);
    chk("ones_head", head(12), 32'b1010_0101_1111);
    chk("ones_eq", {31'b0, eq}, 32'd1);
    chk("ones_dm", dm, 32'hFFFF_FFFF);
    chk("gap_tx", {31'b0, tx}, 32'd0);

    send_frame(32'h0, 2'd3, 1'b0, len, dm, eq, inv, cb);
    chk("zeros_len", len, 32'd1024);
    chk("zeros_inv", {31'b0, inv}, 32'd1);
    chk("zeros_dm", dm, 32'h0);

    for (int s = 0; s < 4; s++) begin
      send_frame(32'hA5A5_A5A5, 2'(s), 1'b0, len, dm, eq, inv, cb);
      chk($sformatf("a5_len_sf%0d", s), len, lens[s]);
      chk($sformatf("a5_dm_sf%0d", s), dm, 32'hA5A5_A5A5);
    end

    // Zero seed becomes 1; a seed load coinciding with send is dropped.
    load(32'h0);
    seed = 32'hDEAD_BEEF; load_seed = 1'b1;
    send_frame(32'hFFFF_FFFF, 2'd0, 1'b0, len, dm, eq, inv, cb);
    load_seed = 1'b0;
    chk("seed1_head", head(8), 32'b1111_0101);

    for (int i = 0; i < 25; i++) begin
      rm = $urandom; rs = 2'($urandom_range(0, 3)); gap = $urandom_range(0, 9);
      send_frame(rm, rs, 1'b0, len, dm, eq, inv, cb);
      chk($sformatf("rnd%0d_len", i), len, lens[rs]);
      chk($sformatf("rnd%0d_dm", i), dm, rm);
      repeat (gap) @(negedge clk);
    end

    load(32'hCAFE_F00D);
    send_frame(32'h3C5A_0FF1, 2'd2, 1'b1, len, dm, eq, inv, cb);
    chk("dist_len", len, 32'd512);
    chk("dist_dm", dm, 32'h3C5A_0FF1);
    for (int i = 0; i < 512; i++) keep[i] = cap[i];
    load(32'hCAFE_F00D);
    send_frame(32'h3C5A_0FF1, 2'd2, 1'b0, len, dm, eq, inv, cb);
    errs = 0;
    for (int i = 0; i < 512; i++) if (keep[i] != cap[i]) errs++;
    chk("repro_len", len, 32'd512);
    chk("repro_chips", errs, 32'd0);

    msg = 32'h1234_ABCD; sf = 2'd2; send = 1'b1;
    @(posedge clk); #1 send = 1'b0;
    repeat (256) @(negedge clk);
    #2 arst_n = 1'b0;
    #1;
    chk("abort_tx", {31'b0, tx}, 32'd0);
    chk("abort_busy", {31'b0, is_sending}, 32'd0);
    @(negedge clk); arst_n = 1'b1;
    @(negedge clk);
    send_frame(32'h1234_ABCD, 2'd2, 1'b0, len, dm, eq, inv, cb);
    chk("post_len", len, 32'd512);
    chk("post_dm", dm, 32'h1234_ABCD);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
